temp_fan_ctrl: RTL and testbench

TEMP_FAN_CTRL -- requirements
Module: temp_fan_ctrl

---
 rtl/temp_fan_ctrl_pkg.sv | 33 +++
 rtl/temp_fan_ctrl_spi_clk_gen.sv | 63 ++++++
 rtl/temp_fan_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_temp_fan_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/temp_fan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// temp_fan_ctrl_pkg
// Shared definitions for the temperature-sensor / fan controller:
//   - FRAME_BITS : number of SCLK periods (bits) in one sensor read frame
//   - TEMP_W     : width of the signed temperature code kept from a frame
//   - state_e    : frame sequencer states
//   - helpers    : state classification used for the busy / chip-select outputs
// -----------------------------------------------------------------------------
package temp_fan_ctrl_pkg;

    localparam int FRAME_BITS = 16;
    localparam int TEMP_W     = 14;
    localparam int BITCNT_W   = $clog2(FRAME_BITS) + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Any state other than IDLE belongs to a frame in progress.
    function automatic logic state_is_busy(input state_e s);
        return (s != ST_IDLE);
    endfunction

    // Chip select is held low only while the sensor is being clocked.
    function automatic logic state_selects_sensor(input state_e s);
        return (s == ST_SETUP) || (s == ST_SHIFT);
    endfunction

endpackage

// File: rtl/temp_fan_ctrl_spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
// Half-period timer for the sensor serial clock. While en_i is high it counts
// CLK_DIV system clocks per half-period and alternates between a "high" half
// (ending in a fall strobe) and a "low" half (ending in a rise strobe).
// Dropping en_i restarts the timer in the high half.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   en_i       : run the timer
//   tick_o     : last cycle of the current half-period
//   fall_o     : tick at the end of a high half (SCLK should fall next)
//   rise_o     : tick at the end of a low half  (SCLK should rise next)
// -----------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic tick_o,
    output logic fall_o,
    output logic rise_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;   // 0: high half, 1: low half
    logic          tick_s;

    assign tick_s = en_i && (cnt_q == CW'(CLK_DIV - 1));
    assign tick_o = tick_s;
    assign fall_o = tick_s && !phase_q;
    assign rise_o = tick_s && phase_q;

    // Next-state for the half-period counter and phase.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick_s) begin
            cnt_d   = '0;
            phase_d = !phase_q;
        end else begin
            cnt_d   = cnt_q + CW'(1);
            phase_d = phase_q;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/temp_fan_ctrl.sv
// -----------------------------------------------------------------------------
// temp_fan_ctrl
// Reads a 16-bit frame from an SPI temperature sensor (manual start or
// periodic poll), keeps the low 14 bits as a signed temperature code and
// drives a fan enable with hysteresis between thr_lo and thr_hi.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   start           : one-cycle manual conversion request
//   thr_hi, thr_lo  : signed fan-on / fan-off thresholds
//   TEMP_DOUT       : sensor serial data in
//   TEMP_CS_n       : sensor chip select (active low)
//   TEMP_SCLK       : serial clock, idle high
//   TEMP_DIN        : sensor serial input, tied low
//   temp_data       : last captured signed temperature code
//   temp_valid      : one-cycle pulse with each temp_data update
//   busy            : a frame is in progress
//   fan_on          : fan enable (on after reset for fail-safe cooling)
// -----------------------------------------------------------------------------
module temp_fan_ctrl
    import temp_fan_ctrl_pkg::*;
#(
    parameter int CLK_DIV     = 25,
    parameter int POLL_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [TEMP_W-1:0] thr_hi,
    input  logic [TEMP_W-1:0] thr_lo,
    input  logic              TEMP_DOUT,
    output logic              TEMP_CS_n,
    output logic              TEMP_SCLK,
    output logic              TEMP_DIN,
    output logic [TEMP_W-1:0] temp_data,
    output logic              temp_valid,
    output logic              busy,
    output logic              fan_on
);

    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    state_e                state_q, state_d;
    logic [PW-1:0]         poll_q, poll_d;
    logic                  pending_q, pending_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic [TEMP_W-1:0]     data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  fan_q, fan_d;

    logic poll_wrap_s, request_s, clk_en_s;
    logic tick_s, fall_s, rise_s;
    logic above_hi_s, below_lo_s;

    assign clk_en_s = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk    (clk),
        .reset  (reset),
        .en_i   (clk_en_s),
        .tick_o (tick_s),
        .fall_o (fall_s),
        .rise_o (rise_s)
    );

    // A start and a poll wrap in the same cycle collapse into one request.
    assign poll_wrap_s = (poll_q == PW'(POLL_CYCLES - 1));
    assign request_s   = start || poll_wrap_s;

    assign above_hi_s = $signed(shift_q[TEMP_W-1:0]) > $signed(thr_hi);
    assign below_lo_s = $signed(shift_q[TEMP_W-1:0]) < $signed(thr_lo);

    // Poll counter, request flag, frame sequencer and output next-state.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        sclk_d    = sclk_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        fan_d     = fan_q;
        pending_d = pending_q;

        if (poll_wrap_s) begin
            poll_d = '0;
        end else begin
            poll_d = poll_q + PW'(1);
        end

        // In IDLE any request (new or held) starts a frame at once, so the flag
        // is only ever set while busy; further requests fold into it.
        if (state_q == ST_IDLE) begin
            pending_d = 1'b0;
        end else if (request_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            ST_IDLE: begin
                bitcnt_d = '0;
                sclk_d   = 1'b1;
                if (pending_q || request_s) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (fall_s) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b0;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                if (rise_s) begin
                    sclk_d   = 1'b1;
                    // Truncating the concatenation drops the oldest bit.
                    shift_d  = FRAME_BITS'({shift_q, TEMP_DOUT});
                    bitcnt_d = bitcnt_q + BITCNT_W'(1);
                end else if (fall_s) begin
                    // The would-be 17th falling edge ends the frame instead.
                    if (bitcnt_q == BITCNT_W'(FRAME_BITS)) begin
                        state_d = ST_HOLD;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (tick_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DONE: begin
                data_d  = shift_q[TEMP_W-1:0];
                valid_d = 1'b1;
                state_d = ST_IDLE;
                // Set has priority when the thresholds overlap.
                if (above_hi_s) begin
                    fan_d = 1'b1;
                end else if (below_lo_s) begin
                    fan_d = 1'b0;
                end else begin
                    fan_d = fan_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b1;
            end
        endcase

        cs_n_d = !state_selects_sensor(state_d);
        busy_d = state_is_busy(state_d);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            poll_q    <= '0;
            pending_q <= 1'b0;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            fan_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            poll_q    <= poll_d;
            pending_q <= pending_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            fan_q     <= fan_d;
        end
    end

    assign TEMP_CS_n  = cs_n_q;
    assign TEMP_SCLK  = sclk_q;
    assign TEMP_DIN   = 1'b0;
    assign temp_data  = data_q;
    assign temp_valid = valid_q;
    assign busy       = busy_q;
    assign fan_on     = fan_q;

endmodule

// File: tb/tb_temp_fan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_temp_fan_ctrl
// Directed frames through a sensor model; expected {temp_data, fan_on} pushed
// per request and checked by a monitor on every temp_valid pulse. A second
// instance with a short poll period checks automatic conversions.
// -----------------------------------------------------------------------------
module tb_temp_fan_ctrl;

    localparam int D   = 2;
    localparam int LAT = 34 * D + 1;

    typedef struct {
        logic [13:0] data;
        logic        fan;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] thr_hi = 14'h0C00;
    logic [13:0] thr_lo = 14'h0A00;
    logic        dout = 1'b0;
    logic        cs_n, sclk, din, temp_valid, busy, fan_on;
    logic [13:0] temp_data;

    logic        p_cs_n, p_sclk, p_din, p_valid, p_busy, p_fan;
    logic [13:0] p_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int valid_cnt = 0;
    int rises = 0;
    int cs_fall_cyc = 0;
    int bit_idx = 15;
    int n0;
    logic [15:0] frame_word = 16'h0000;
    logic cs_prev = 1'b1, sclk_prev = 1'b1, p_cs_prev = 1'b1;
    exp_t sb_q[$];
    int poll_falls[$];

    temp_fan_ctrl #(.CLK_DIV(D)) dut (
        .clk(clk), .reset(reset), .start(start), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .TEMP_DOUT(dout), .TEMP_CS_n(cs_n), .TEMP_SCLK(sclk), .TEMP_DIN(din),
        .temp_data(temp_data), .temp_valid(temp_valid), .busy(busy), .fan_on(fan_on)
    );

    temp_fan_ctrl #(.CLK_DIV(D), .POLL_CYCLES(200)) dut_poll (
        .clk(clk), .reset(reset), .start(1'b0), .thr_hi(14'h0C00), .thr_lo(14'h0A00),
        .TEMP_DOUT(1'b0), .TEMP_CS_n(p_cs_n), .TEMP_SCLK(p_sclk), .TEMP_DIN(p_din),
        .temp_data(p_data), .temp_valid(p_valid), .busy(p_busy), .fan_on(p_fan)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rel_cyc <= reset ? 0 : rel_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sensor model: restart at CS fall (SCLK is high then), shift out MSB-first on SCLK falls.
    always @(negedge cs_n or negedge sclk) begin
        if (sclk === 1'b1) begin
            bit_idx = 15;
        end else if (cs_n === 1'b0) begin
            dout    = (bit_idx >= 0) ? frame_word[bit_idx[3:0]] : 1'b0;
            bit_idx = bit_idx - 1;
        end
    end

    // Monitor: frame timing, SCLK rise count and scoreboard compare on temp_valid.
    always @(negedge clk) begin
        if (cs_prev === 1'b1 && cs_n === 1'b0) begin
            cs_fall_cyc = cyc;
            rises = 0;
            check("busy_at_cs_fall", 32'(busy), 32'd1);
        end
        if (cs_n === 1'b0 && sclk_prev === 1'b0 && sclk === 1'b1) rises++;
        if (temp_valid === 1'b1) begin
            exp_t e;
            valid_cnt++;
            check("valid_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("temp_data", 32'(temp_data), 32'(e.data));
                check("fan_on", 32'(fan_on), 32'(e.fan));
                check("latency", 32'(cyc - cs_fall_cyc), 32'(LAT));
                check("sclk_periods", 32'(rises), 32'd16);
            end
        end
        if (p_cs_prev === 1'b1 && p_cs_n === 1'b0) poll_falls.push_back(rel_cyc);
        cs_prev   = cs_n;
        sclk_prev = sclk;
        p_cs_prev = p_cs_n;
    end

    task automatic wait_valid(input int target, input int budget);
        int k = 0;
        while (valid_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frame_timeout", 32'(valid_cnt >= target), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] word, input logic [13:0] exp_d, input logic exp_f);
        int base;
        exp_t e;
        e.data = exp_d;
        e.fan  = exp_f;
        frame_word = word;
        sb_q.push_back(e);
        base = valid_cnt;
        pulse_start();
        wait_valid(base + 1, 200);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int k;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_din", 32'(din), 32'd0);
        check("rst_data", 32'(temp_data), 32'd0);
        check("rst_valid", 32'(temp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fan", 32'(fan_on), 32'd1);
        check("rst_poll_busy", 32'(p_busy), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Hysteresis sequence with thr_hi=0x0C00, thr_lo=0x0A00.
        run_frame(16'h0C80, 14'h0C80, 1'b1);
        run_frame(16'h0B00, 14'h0B00, 1'b1);
        run_frame(16'h0900, 14'h0900, 1'b0);
        run_frame(16'h0C80, 14'h0C80, 1'b1);
        // Negative code -256 against thr_lo=0 must clear (signed compare).
        thr_lo = 14'h0000;
        run_frame(16'h3F00, 14'h3F00, 1'b0);
        // Overlapping thresholds: set wins; bits [15:14] dropped.
        thr_hi = 14'h0100;
        thr_lo = 14'h1000;
        run_frame(16'hC800, 14'h0800, 1'b1);
        check("din_const", 32'(din), 32'd0);

        // Three extra starts during one busy frame -> exactly two frames.
        thr_hi = 14'h0C00;
        thr_lo = 14'h0A00;
        frame_word = 16'h0B55;
        e.data = 14'h0B55;
        e.fan  = 1'b1;
        sb_q.push_back(e);
        sb_q.push_back(e);
        n0 = valid_cnt;
        pulse_start();
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pulse_start();
            repeat (10) @(negedge clk);
        end
        wait_valid(n0 + 2, 300);
        repeat (100) @(negedge clk);
        check("triple_frames", 32'(valid_cnt - n0), 32'd2);

        // Automatic polling instance: CS_n falls 200, 400, 600 cycles after reset.
        check("poll_count", 32'(poll_falls.size() >= 3), 32'd1);
        if (poll_falls.size() >= 3) begin
            check("poll_1", 32'(poll_falls[0]), 32'd200);
            check("poll_2", 32'(poll_falls[1]), 32'd400);
            check("poll_3", 32'(poll_falls[2]), 32'd600);
        end

        // Reset at the 8th SCLK rising edge aborts the frame.
        frame_word = 16'h1234;
        n0 = valid_cnt;
        pulse_start();
        k = 0;
        while (rises < 8 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_8th", 32'(rises >= 8), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_no_valid", 32'(valid_cnt - n0), 32'd0);
        check("abort_data", 32'(temp_data), 32'd0);
        check("abort_fan", 32'(fan_on), 32'd1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
